// File: rtl/sram_fifo.sv
// rtl/sram_fifo.sv - show-ahead FIFO around a 1W1R SRAM, hiding its 1-cycle read latency
// Optional sticky overflow/underflow error output enabled by defining SRAM_FIFO_ERROR_EN.

module sram1w1r #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] read_data
);
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] read_data_q;
    logic [DATA_WIDTH-1:0] read_data_d;

    // Same-address write forwards straight to the read register.
    always_comb begin
        read_data_d = read_data_q;
        if (read_en) begin
            if (write_en && (write_addr == read_addr)) begin
                read_data_d = write_data;
            end else begin
                read_data_d = mem_q[read_addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[write_addr] <= write_data;
        end
        read_data_q <= read_data_d;
    end

    assign read_data = read_data_q;
endmodule

module sram_fifo #(
    parameter int DEPTH                 = 8,
    parameter int DATA_WIDTH            = 32,
    parameter int ALMOST_FULL_THRESHOLD = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enqueue_en,
    input  logic [DATA_WIDTH-1:0]        enqueue_value,
    input  logic                         dequeue_en,
    output logic [DATA_WIDTH-1:0]        dequeue_value,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef SRAM_FIFO_ERROR_EN
    ,
    output logic                         error
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(ALMOST_FULL_THRESHOLD);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic          push, pop;
    logic          write_en;
    logic [PW-1:0] read_addr;

    always_comb begin
        push     = enqueue_en && (!full_q || dequeue_en);
        pop      = dequeue_en && !empty_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
        empty_d       = (count_d == CNT_ZERO);
        full_d        = (count_d == CNT_FULL);
        almost_full_d = (count_d >= CNT_AF);
        write_en      = push && !reset;
        // Look ahead to the post-pop head so it lands on the output one edge later.
        read_addr     = rd_ptr_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            almost_full_q <= almost_full_d;
        end
    end

    sram1w1r #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (PW)
    ) u_sram (
        .clk        (clk),
        .write_en   (write_en),
        .write_addr (wr_ptr_q),
        .write_data (enqueue_value),
        .read_en    (1'b1),
        .read_addr  (read_addr),
        .read_data  (dequeue_value)
    );

    assign empty       = empty_q;
    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;

`ifdef SRAM_FIFO_ERROR_EN
    logic error_q, error_d;
    logic overflow, underflow;

    always_comb begin
        overflow  = enqueue_en && full_q && !dequeue_en;
        underflow = dequeue_en && empty_q;
        error_d   = error_q || overflow || underflow;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && overflow) begin
            $error("sram_fifo: enqueue while full");
        end
        if (!reset && underflow) begin
            $error("sram_fifo: dequeue while empty");
        end
    end
`endif
`endif
endmodule

// File: tb/tb_sram_fifo.sv
// tb/tb_sram_fifo.sv - directed and randomized checks of sram_fifo against a queue model

module tb_sram_fifo;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int AF    = DEPTH - 1;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enqueue_en = 1'b0;
    logic [DW-1:0] enqueue_value = '0;
    logic          dequeue_en = 1'b0;
    logic [DW-1:0] dequeue_value;
    logic          empty, full, almost_full;
    logic [CW-1:0] count;
`ifdef SRAM_FIFO_ERROR_EN
    logic          error;
`endif

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] model_q[$];

    always #5 clk = ~clk;

    sram_fifo #(
        .DEPTH                 (DEPTH),
        .DATA_WIDTH            (DW),
        .ALMOST_FULL_THRESHOLD (AF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enqueue_en    (enqueue_en),
        .enqueue_value (enqueue_value),
        .dequeue_en    (dequeue_en),
        .dequeue_value (dequeue_value),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .count         (count)
`ifdef SRAM_FIFO_ERROR_EN
        ,
        .error         (error)
`endif
    );

    task automatic drive(input logic rst, input logic en, input logic [DW-1:0] val, input logic deq);
        bit push_ok, pop_ok;
        reset = rst;
        enqueue_en = en;
        enqueue_value = val;
        dequeue_en = deq;
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            pop_ok  = deq && (model_q.size() != 0);
            push_ok = en && ((model_q.size() < DEPTH) || deq);
            if (pop_ok) void'(model_q.pop_front());
            if (push_ok) model_q.push_back(val);
        end
        #1;
        reset = 1'b0;
        enqueue_en = 1'b0;
        dequeue_en = 1'b0;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (count !== CW'(0)) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%b exp=0", almost_full); end
    endtask

    task automatic test_single();
        drive(1'b0, 1'b1, 32'hA5, 1'b0);
        checks++; if (empty !== 1'b0) begin failures++; $display("FAIL single_empty got=%b exp=0", empty); end
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL single_count got=%0d exp=1", count); end
        checks++; if (dequeue_value !== 32'hA5) begin failures++; $display("FAIL single_value got=%0h exp=a5", dequeue_value); end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL single_pop_empty got=%b exp=1", empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            drive(1'b0, 1'b1, DW'(i), 1'b0);
            checks++; if (count !== CW'(i)) begin failures++; $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, i); end
            checks++; if (full !== (i == DEPTH)) begin failures++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, i == DEPTH); end
            checks++; if (almost_full !== (i >= AF)) begin failures++; $display("FAIL fill_af i=%0d got=%b exp=%b", i, almost_full, i >= AF); end
            checks++; if (dequeue_value !== DW'(1)) begin failures++; $display("FAIL fill_head i=%0d got=%0h exp=1", i, dequeue_value); end
        end
        drive(1'b0, 1'b1, DW'(99), 1'b0);
        checks++; if (count !== CW'(DEPTH)) begin failures++; $display("FAIL overflow_count got=%0d exp=%0d", count, DEPTH); end
        checks++; if (dequeue_value !== DW'(1)) begin failures++; $display("FAIL overflow_head got=%0h exp=1", dequeue_value); end
        for (int i = 1; i <= DEPTH; i++) begin
            checks++; if (dequeue_value !== DW'(i)) begin failures++; $display("FAIL drain_value i=%0d got=%0h exp=%0h", i, dequeue_value, i); end
            drive(1'b0, 1'b0, '0, 1'b1);
        end
        checks++; if (empty !== 1'b1 || count !== CW'(0)) begin failures++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, DW'(200 + i), 1'b0);
        for (int i = 0; i < 20; i++) begin
            checks++; if (dequeue_value !== DW'(200 + i)) begin failures++; $display("FAIL wrap_head i=%0d got=%0d exp=%0d", i, dequeue_value, 200 + i); end
            drive(1'b0, 1'b1, DW'(200 + DEPTH + i), 1'b1);
            checks++; if (count !== CW'(DEPTH) || full !== 1'b1) begin failures++; $display("FAIL wrap_count i=%0d got=%0d/%b exp=%0d/1", i, count, full, DEPTH); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++; if (dequeue_value !== DW'(220 + i)) begin failures++; $display("FAIL wrap_drain i=%0d got=%0d exp=%0d", i, dequeue_value, 220 + i); end
            drive(1'b0, 1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_simul_empty();
        drive(1'b0, 1'b1, 32'h11, 1'b1);
        checks++; if (count !== CW'(1)) begin failures++; $display("FAIL pushpop_empty_count got=%0d exp=1", count); end
        checks++; if (dequeue_value !== 32'h11) begin failures++; $display("FAIL pushpop_empty_value got=%0h exp=11", dequeue_value); end
        drive(1'b0, 1'b0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (count !== CW'(0) || empty !== 1'b1) begin failures++; $display("FAIL underflow got=%0d/%b exp=0/1", count, empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, DW'(32'h50 + i), 1'b0);
        checks++; if (count !== CW'(5)) begin failures++; $display("FAIL pre_reset_count got=%0d exp=5", count); end
        drive(1'b1, 1'b1, 32'hDEAD, 1'b0);
        checks++; if (count !== CW'(0) || empty !== 1'b1) begin failures++; $display("FAIL mid_reset got=%0d/%b exp=0/1", count, empty); end
        drive(1'b0, 1'b1, 32'h3C, 1'b0);
        checks++; if (dequeue_value !== 32'h3C || count !== CW'(1)) begin failures++; $display("FAIL post_reset got=%0h/%0d exp=3c/1", dequeue_value, count); end
        drive(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_random();
        int push_pct;
        for (int i = 0; i < 600; i++) begin
            push_pct = (i < 200) ? 75 : (i < 400) ? 30 : 55;
            drive(1'b0, $urandom_range(0, 99) < push_pct, $urandom, $urandom_range(0, 99) < 50);
            checks++; if (count !== CW'(model_q.size())) begin failures++; $display("FAIL rand_count i=%0d got=%0d exp=%0d", i, count, model_q.size()); end
            checks++;
            if (empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH) || almost_full !== (model_q.size() >= AF)) begin
                failures++; $display("FAIL rand_flags i=%0d got=%b%b%b exp=%b%b%b", i, empty, full, almost_full,
                    model_q.size() == 0, model_q.size() == DEPTH, model_q.size() >= AF);
            end
            if (model_q.size() != 0) begin
                checks++; if (dequeue_value !== model_q[0]) begin failures++; $display("FAIL rand_head i=%0d got=%0h exp=%0h", i, dequeue_value, model_q[0]); end
            end
        end
    endtask

`ifdef SRAM_FIFO_ERROR_EN
    task automatic test_error();
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL error_reset got=%b exp=0", error); end
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL error_set got=%b exp=1", error); end
        drive(1'b0, 1'b1, 32'h7, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b1);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b exp=1", error); end
        drive(1'b1, 1'b0, '0, 1'b0);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL error_clear got=%b exp=0", error); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_wrap();
        test_simul_empty();
        test_reset_mid();
        test_random();
`ifdef SRAM_FIFO_ERROR_EN
        test_error();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
